// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared control-bit indices, FSM state type and defaults for the MEM stage
package mips_pkg;

  localparam int CTL_BRANCH   = 2;
  localparam int CTL_MEMREAD  = 1;
  localparam int CTL_MEMWRITE = 0;
  localparam int CTL_REGWRITE = 1;
  localparam int CTL_MEMTOREG = 0;

  localparam int DEFAULT_DEPTH = 256;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  function automatic logic is_mem_op(input logic [2:0] ctl_mem);
    return ctl_mem[CTL_MEMREAD] | ctl_mem[CTL_MEMWRITE];
  endfunction

endpackage

// File: rtl/data_memory.sv
// rtl/data_memory.sv - word-addressed data RAM, combinational read, synchronous write
module data_memory #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  // No reset: contents survive a pipeline reset.
  logic [31:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MIPS MEM stage: branch resolve, wait-state data memory access, MEM/WB register
// Optional MEM_MISALIGN_TRAP_EN adds the misalign output and suppresses misaligned stores.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  ctl_wb_in,
  input  logic [2:0]  ctl_mem_in,
  input  logic [31:0] add_result_in,
  input  logic        zero_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] rdata2_in,
  input  logic [4:0]  write_reg_in,
  output logic        pc_src,
  output logic [31:0] branch_target,
  output logic        stall,
  output logic [1:0]  ctl_wb_out,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  write_reg_out
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic              mem_read;
  logic              mem_write;
  logic              mem_op;
  logic              misaligned;
  logic              complete;
  logic              stall_c;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;

  logic [1:0]        ctl_wb_q, ctl_wb_d;
  logic [31:0]       read_data_q, read_data_d;
  logic [31:0]       alu_result_q, alu_result_d;
  logic [4:0]        write_reg_q, write_reg_d;
  logic              misalign_q, misalign_d;

  assign mem_read  = ctl_mem_in[CTL_MEMREAD];
  assign mem_write = ctl_mem_in[CTL_MEMWRITE];
  assign mem_op    = is_mem_op(ctl_mem_in);
  assign mem_addr  = alu_result_in[ADDR_W+1:2];

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = mem_op & (alu_result_in[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // complete marks the cycle whose edge performs the access and loads real MEM/WB values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_c  = 1'b0;
    complete = 1'b1;
    case (state_q)
      IDLE: begin
        if (mem_op && (WAIT_STATES > 0)) begin
          stall_c  = 1'b1;
          complete = 1'b0;
          cnt_d    = WAIT_LOAD;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          stall_c  = 1'b1;
          complete = 1'b0;
          cnt_d    = cnt_q - 4'd1;
        end else begin
          state_d  = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = 4'd0;
      end
    endcase
  end

  assign mem_we = complete & mem_write & ~misaligned;

  data_memory #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_dmem (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (rdata2_in),
    .rdata_o (mem_rdata)
  );

  // Stalled cycles push a bubble; a simultaneous read+write is treated as a store.
  always_comb begin
    ctl_wb_d     = 2'b00;
    read_data_d  = 32'd0;
    alu_result_d = 32'd0;
    write_reg_d  = 5'd0;
    misalign_d   = 1'b0;
    if (complete) begin
      ctl_wb_d     = misaligned ? 2'b00 : ctl_wb_in;
      read_data_d  = (mem_read && !mem_write && !misaligned) ? mem_rdata : 32'd0;
      alu_result_d = alu_result_in;
      write_reg_d  = write_reg_in;
      misalign_d   = misaligned;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      ctl_wb_q     <= 2'b00;
      read_data_q  <= 32'd0;
      alu_result_q <= 32'd0;
      write_reg_q  <= 5'd0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ctl_wb_q     <= ctl_wb_d;
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result_d;
      write_reg_q  <= write_reg_d;
      misalign_q   <= misalign_d;
    end
  end

  assign stall          = stall_c & ~reset;
  assign pc_src         = ctl_mem_in[CTL_BRANCH] & zero_in & ~stall_c;
  assign branch_target  = add_result_in;
  assign ctl_wb_out     = ctl_wb_q;
  assign read_data_out  = read_data_q;
  assign alu_result_out = alu_result_q;
  assign write_reg_out  = write_reg_q;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = misalign_q;
`else
  logic unused_misalign;
  assign unused_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench: zero-wait and three-wait-state instances vs a word-array model
module tb_mem_wb_stage;

  typedef struct packed {
    logic [1:0]  wb;
    logic [2:0]  mem;
    logic [31:0] add;
    logic        zero;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  wr;
  } instr_t;

  typedef struct packed {
    logic        pc;
    logic [1:0]  wb;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic        mis;
  } out_t;

  typedef struct {
    instr_t in;
    out_t   exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  wb_in   [2];
  logic [2:0]  mem_in  [2];
  logic [31:0] add_in  [2];
  logic        zin     [2];
  logic [31:0] alu_in  [2];
  logic [31:0] wd_in   [2];
  logic [4:0]  wr_in   [2];
  logic        pc_src  [2];
  logic [31:0] bt      [2];
  logic        stall   [2];
  logic [1:0]  wb_out  [2];
  logic [31:0] rd_out  [2];
  logic [31:0] alu_out [2];
  logic [4:0]  wr_out  [2];
`ifdef MEM_MISALIGN_TRAP_EN
  logic        mis_out [2];
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] model [2][256];

  always #5 clk = ~clk;

  mem_wb_stage #(.DEPTH(256), .ADDR_W(8), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .ctl_wb_in(wb_in[0]), .ctl_mem_in(mem_in[0]),
    .add_result_in(add_in[0]), .zero_in(zin[0]), .alu_result_in(alu_in[0]),
    .rdata2_in(wd_in[0]), .write_reg_in(wr_in[0]), .pc_src(pc_src[0]),
    .branch_target(bt[0]), .stall(stall[0]), .ctl_wb_out(wb_out[0]),
    .read_data_out(rd_out[0]), .alu_result_out(alu_out[0]), .write_reg_out(wr_out[0])
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign(mis_out[0])
`endif
  );

  mem_wb_stage #(.DEPTH(256), .ADDR_W(8), .WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(reset), .ctl_wb_in(wb_in[1]), .ctl_mem_in(mem_in[1]),
    .add_result_in(add_in[1]), .zero_in(zin[1]), .alu_result_in(alu_in[1]),
    .rdata2_in(wd_in[1]), .write_reg_in(wr_in[1]), .pc_src(pc_src[1]),
    .branch_target(bt[1]), .stall(stall[1]), .ctl_wb_out(wb_out[1]),
    .read_data_out(rd_out[1]), .alu_result_out(alu_out[1]), .write_reg_out(wr_out[1])
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign(mis_out[1])
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic instr_t mk(input logic [1:0] wb, input logic [2:0] mem, input logic [31:0] add,
                                input logic zero, input logic [31:0] alu, input logic [31:0] wd,
                                input logic [4:0] wr);
    instr_t t;
    t.wb = wb; t.mem = mem; t.add = add; t.zero = zero; t.alu = alu; t.wd = wd; t.wr = wr;
    return t;
  endfunction

  function automatic out_t mko(input logic pc, input logic [1:0] wb, input logic [31:0] rdata,
                               input logic [31:0] alu, input logic [4:0] wr);
    out_t o;
    o.pc = pc; o.wb = wb; o.rdata = rdata; o.alu = alu; o.wr = wr; o.mis = 1'b0;
    return o;
  endfunction

  function automatic logic is_mis(input instr_t t);
`ifdef MEM_MISALIGN_TRAP_EN
    return (t.mem[1] | t.mem[0]) && (t.alu % 4 != 0);
`else
    return 1'b0;
`endif
  endfunction

  // Reference: word index is the byte address divided by 4, modulo the 256-word array.
  function automatic out_t expect_of(input int w, input instr_t t);
    out_t e;
    int   idx;
    logic mis;
    idx     = int'((t.alu / 4) % 256);
    mis     = is_mis(t);
    e.pc    = t.mem[2] & t.zero;
    e.wb    = mis ? 2'b00 : t.wb;
    e.rdata = (t.mem[1] && !t.mem[0] && !mis) ? model[w][idx] : 32'd0;
    e.alu   = t.alu;
    e.wr    = t.wr;
    e.mis   = mis;
    return e;
  endfunction

  task automatic drive(input int w, input instr_t t);
    wb_in[w] = t.wb; mem_in[w] = t.mem; add_in[w] = t.add; zin[w] = t.zero;
    alu_in[w] = t.alu; wd_in[w] = t.wd; wr_in[w] = t.wr;
  endtask

  task automatic idle(input int w);
    drive(w, mk(2'b00, 3'b000, 32'd0, 1'b0, 32'd0, 32'd0, 5'd0));
  endtask

  task automatic exec(input int w, input instr_t t, output out_t o, output int stalls);
    drive(w, t);
    stalls = 0;
    @(negedge clk);
    while (stall[w] === 1'b1 && stalls < 20) begin
      check("pc_src_in_stall", {31'd0, pc_src[w]}, 32'd0);
      stalls++;
      @(posedge clk); #1;
      check("bubble_wb", {30'd0, wb_out[w]}, 32'd0);
      check("bubble_rdata", rd_out[w], 32'd0);
      check("bubble_alu", alu_out[w], 32'd0);
      check("bubble_wr", {27'd0, wr_out[w]}, 32'd0);
      @(negedge clk);
    end
    if (stalls >= 20) begin
      checks++; errors++;
      $display("FAIL stall_timeout actual=%0d expected=<20", stalls);
    end
    o.pc = pc_src[w];
    check("branch_target", bt[w], t.add);
    @(posedge clk); #1;
    o.wb = wb_out[w]; o.rdata = rd_out[w]; o.alu = alu_out[w]; o.wr = wr_out[w];
`ifdef MEM_MISALIGN_TRAP_EN
    o.mis = mis_out[w];
`else
    o.mis = 1'b0;
`endif
    if (t.mem[0] && !is_mis(t)) model[w][int'((t.alu / 4) % 256)] = t.wd;
  endtask

  task automatic cmp_out(input string tag, input out_t a, input out_t e);
    check({tag, "_pc_src"}, {31'd0, a.pc}, {31'd0, e.pc});
    check({tag, "_ctl_wb"}, {30'd0, a.wb}, {30'd0, e.wb});
    check({tag, "_read_data"}, a.rdata, e.rdata);
    check({tag, "_alu_result"}, a.alu, e.alu);
    check({tag, "_write_reg"}, {27'd0, a.wr}, {27'd0, e.wr});
`ifdef MEM_MISALIGN_TRAP_EN
    check({tag, "_misalign"}, {31'd0, a.mis}, {31'd0, e.mis});
`endif
  endtask

  task automatic check_reset_outputs(input string tag, input int w);
    check({tag, "_stall"}, {31'd0, stall[w]}, 32'd0);
    check({tag, "_wb"}, {30'd0, wb_out[w]}, 32'd0);
    check({tag, "_rdata"}, rd_out[w], 32'd0);
    check({tag, "_alu"}, alu_out[w], 32'd0);
    check({tag, "_wr"}, {27'd0, wr_out[w]}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    vec_t   tbl [10];
    out_t   o;
    out_t   e;
    instr_t t;
    int     s;
    int     w;
    logic [31:0] prior;

    reset = 1'b1;
    idle(0); idle(1);
    #12;
    check_reset_outputs("reset0", 0);
    check_reset_outputs("reset3", 1);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) begin
        exec(d, mk(2'b00, 3'b001, 32'd0, 1'b0, i * 4, 32'hC0DE0000 ^ (d << 12) ^ i, 5'd0), o, s);
      end
      idle(d);
    end

    tbl[0] = '{mk(2'b00, 3'b001, 32'h0,  1'b0, 32'h10,       32'hDEADBEEF, 5'd0),  mko(1'b0, 2'b00, 32'h0,        32'h10,       5'd0)};
    tbl[1] = '{mk(2'b11, 3'b010, 32'h0,  1'b0, 32'h10,       32'h0,        5'd5),  mko(1'b0, 2'b11, 32'hDEADBEEF, 32'h10,       5'd5)};
    tbl[2] = '{mk(2'b00, 3'b100, 32'h40, 1'b1, 32'h0,        32'h0,        5'd0),  mko(1'b1, 2'b00, 32'h0,        32'h0,        5'd0)};
    tbl[3] = '{mk(2'b00, 3'b100, 32'h40, 1'b0, 32'h0,        32'h0,        5'd0),  mko(1'b0, 2'b00, 32'h0,        32'h0,        5'd0)};
    tbl[4] = '{mk(2'b00, 3'b001, 32'h0,  1'b0, 32'h400,      32'hA5A5A5A5, 5'd0),  mko(1'b0, 2'b00, 32'h0,        32'h400,      5'd0)};
    tbl[5] = '{mk(2'b11, 3'b010, 32'h0,  1'b0, 32'h0,        32'h0,        5'd12), mko(1'b0, 2'b11, 32'hA5A5A5A5, 32'h0,        5'd12)};
    tbl[6] = '{mk(2'b10, 3'b011, 32'h0,  1'b0, 32'h24,       32'h77,       5'd4),  mko(1'b0, 2'b10, 32'h0,        32'h24,       5'd4)};
    tbl[7] = '{mk(2'b11, 3'b010, 32'h0,  1'b0, 32'h24,       32'h0,        5'd6),  mko(1'b0, 2'b11, 32'h77,       32'h24,       5'd6)};
    tbl[8] = '{mk(2'b10, 3'b000, 32'h0,  1'b1, 32'h12345678, 32'hFFFF,     5'd9),  mko(1'b0, 2'b10, 32'h0,        32'h12345678, 5'd9)};
    tbl[9] = '{mk(2'b01, 3'b010, 32'h0,  1'b0, 32'hFFFFFC10, 32'h0,        5'd1),  mko(1'b0, 2'b01, 32'hDEADBEEF, 32'hFFFFFC10, 5'd1)};

    for (int i = 0; i < 10; i++) begin
      exec(0, tbl[i].in, o, s);
      cmp_out($sformatf("tbl%0d", i), o, tbl[i].exp);
      check($sformatf("tbl%0d_stalls", i), s, 0);
    end
    idle(0);

    // Three wait states: store, reload, then a branch whose pc_src must stay low until completion.
    exec(1, mk(2'b00, 3'b001, 32'h0, 1'b0, 32'h20, 32'h12345678, 5'd0), o, s);
    check("ws3_store_stalls", s, 3);
    cmp_out("ws3_store", o, mko(1'b0, 2'b00, 32'h0, 32'h20, 5'd0));
    exec(1, mk(2'b11, 3'b010, 32'h0, 1'b0, 32'h20, 32'h0, 5'd7), o, s);
    check("ws3_load_stalls", s, 3);
    cmp_out("ws3_load", o, mko(1'b0, 2'b11, 32'h12345678, 32'h20, 5'd7));
    exec(1, mk(2'b11, 3'b110, 32'h80, 1'b1, 32'h20, 32'h0, 5'd8), o, s);
    check("ws3_brload_stalls", s, 3);
    cmp_out("ws3_brload", o, mko(1'b1, 2'b11, 32'h12345678, 32'h20, 5'd8));

    // Reset in the middle of a stalled store: nothing may be written.
    exec(0, mk(2'b10, 3'b000, 32'h0, 1'b0, 32'hCAFE, 32'h0, 5'd3), o, s);
    prior = model[1][2];
    drive(1, mk(2'b00, 3'b001, 32'h0, 1'b0, 32'h8, 32'h1, 5'd0));
    @(posedge clk); #1;
    check("abort_stall_c1", {31'd0, stall[1]}, 32'd1);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst0", 0);
    check_reset_outputs("midrst3", 1);
    idle(0); idle(1);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    exec(1, mk(2'b11, 3'b010, 32'h0, 1'b0, 32'h8, 32'h0, 5'd2), o, s);
    cmp_out("abort_reload", o, mko(1'b0, 2'b11, prior, 32'h8, 5'd2));
    idle(1);

    for (int n = 0; n < 160; n++) begin
      logic [2:0]  mem;
      logic [31:0] addr;
      w = int'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: mem = 3'b000;
        1: mem = 3'b010;
        2: mem = 3'b001;
        3: mem = 3'b011;
        default: mem = {1'b1, 1'($urandom_range(0, 1)), 1'b0};
      endcase
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      t = mk(2'($urandom), mem, $urandom, 1'($urandom), addr, $urandom, 5'($urandom));
      e = expect_of(w, t);
      idle(0); idle(1);
      exec(w, t, o, s);
      cmp_out($sformatf("rnd%0d", n), o, e);
      check($sformatf("rnd%0d_stalls", n), s, (w == 1 && (mem[1] || mem[0])) ? 3 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MIPS memory-access stage sitting directly downstream of the EX/MEM pipeline register.
- Consumes the EX/MEM outputs (WB/MEM control, branch target, zero, ALU result, store data, destination register), resolves branches, and accesses a word-addressed data memory with configurable wait states.
- Registers the results into the MEM/WB pipeline register for the write-back stage.
- Raises `stall` upstream while a multi-cycle access is in progress.

Parameters:
- DEPTH, 256, number of 32-bit words in the data memory.
- ADDR_W, 8, word-index width; must equal clog2(DEPTH).
- WAIT_STATES, 0, extra cycles per load/store (0..15); 0 means single-cycle access.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- ctl_wb_in  input  2  [1]=RegWrite, [0]=MemtoReg.
- ctl_mem_in  input  3  [2]=Branch, [1]=MemRead, [0]=MemWrite.
- add_result_in  input  32  branch target.
- zero_in  input  1  ALU zero flag.
- alu_result_in  input  32  memory byte address, or ALU result.
- rdata2_in  input  32  store data.
- write_reg_in  input  5  destination register.
- pc_src  output  1  branch taken (combinational).
- branch_target  output  32  add_result_in passthrough (combinational).
- stall  output  1  upstream must hold EX/MEM contents.
- ctl_wb_out  output  2  registered WB control.
- read_data_out  output  32  registered load data.
- alu_result_out  output  32  registered ALU result.
- write_reg_out  output  5  registered destination register.

Behaviour:
- Reset (async, active-high): all MEM/WB outputs are 0, FSM goes to IDLE, wait counter is 0. Memory contents are not cleared.
- pc_src = Branch & zero_in. It is forced to 0 while stall=1.
- Memory index = alu_result_in[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH words.
- Reads are combinational from the array. Writes are synchronous, on the rising clk edge of the completion cycle only.
- A memory operation (mem_op) is MemRead|MemWrite. If both bits are set, MemWrite wins and read_data_out is loaded with 0.
- FSM states:
  - IDLE, no mem_op, or mem_op with WAIT_STATES=0: the access completes this cycle; MEM/WB loads normally; stall=0.
  - IDLE, mem_op with WAIT_STATES>0: stall=1; counter loads WAIT_STATES-1; MEM/WB loads a bubble (all fields 0); go to WAIT.
  - WAIT, counter>0: stall=1; counter decrements; bubble loaded.
  - WAIT, counter==0: stall=0; the access completes (write performed, or read data captured); MEM/WB loads real values; go to IDLE.
- Latency: one cycle from input to MEM/WB for non-memory ops. A memory op occupies WAIT_STATES+1 cycles.
- Inputs must stay stable while stall=1; upstream guarantees this.
- A store writes exactly once per instruction, even when stalled.
- The MEM/WB register loads every cycle; it has no enable.
- Reset asserted during WAIT aborts the access: no write occurs, FSM returns to IDLE, outputs clear.
- Non-memory instructions pass alu_result_in, write_reg_in and ctl_wb_in through; read_data_out becomes 0.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- When defined:
  - A mem_op with alu_result_in[1:0]!=0 suppresses the write.
  - Adds output `misalign` (1 bit, registered, reset 0), set for one cycle alongside the completing MEM/WB load.
  - ctl_wb_out for that instruction is forced to 0.
- When undefined: address bits [1:0] are ignored, no `misalign` port exists, and a misaligned access behaves as the aligned word access.

Decomposition:
- Shared package mips_pkg holds:
  - control bit-index constants (CTL_BRANCH=2, CTL_MEMREAD=1, CTL_MEMWRITE=0, CTL_REGWRITE=1, CTL_MEMTOREG=0);
  - the FSM state enum {IDLE, WAIT};
  - the default DEPTH.
- Natural sub-module: data_memory (array, combinational read, synchronous write with write enable).
- The FSM and the MEM/WB register stay in the top.

Test Plan:
- Reset mid-stream: assert reset asynchronously between edges -> all outputs 0 immediately; stall=0.
- WAIT_STATES=0, store 0xDEADBEEF to address 0x10, then load 0x10 -> next cycle read_data_out=0xDEADBEEF, write_reg_out=load's rd, ctl_wb_out=2'b11.
- Branch=1 with zero_in=1, add_result_in=0x40 -> pc_src=1 and branch_target=0x40 in the same cycle; with zero_in=0 -> pc_src=0.
- WAIT_STATES=3, store 0x12345678 to 0x20, inputs held -> stall=1 for 3 cycles with bubbles on MEM/WB; memory written exactly once on the 4th cycle; a following load returns 0x12345678.
- Address wrap, DEPTH=256: store 0xA5A5A5A5 to 0x400, load from 0x000 -> 0xA5A5A5A5.
- Reset during WAIT, WAIT_STATES=3, store 0x1 to 0x8, reset on cycle 2 -> a later load of 0x8 returns the prior value. With MEM_MISALIGN_TRAP_EN, store to 0x22 -> misalign=1, no write, ctl_wb_out=0.
